// File: rtl/cpu_if.sv
// Bus bundle between the instruction source and cpu_top.
// Carries the instruction word in, the result out, and optional flags.
interface cpu_if;
   logic [15:0] datain;
   logic [15:0] dataout;
`ifdef CPU_FLAGS_EN
   logic [1:0]  flags;
`endif

`ifdef CPU_FLAGS_EN
   modport master (output datain, input dataout, input flags);
   modport slave  (input datain, output dataout, output flags);
`else
   modport master (output datain, input dataout);
   modport slave  (input datain, output dataout);
`endif
endinterface

// File: rtl/cpu_top.sv
// Single-cycle 16-bit core with an 8 x 16 register file.
// Optional macro CPU_FLAGS_EN adds {carry, zero} flags for ADD/SUB/ADDI.
module cpu_top (
   input logic clk,
   input logic rst,
   cpu_if.slave bus
);

   localparam logic [3:0] OP_LDI  = 4'b0000;
   localparam logic [3:0] OP_LUI  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_NOT  = 4'b0111;
   localparam logic [3:0] OP_SHL  = 4'b1000;
   localparam logic [3:0] OP_SHR  = 4'b1001;
   localparam logic [3:0] OP_ADDI = 4'b1010;
   localparam logic [3:0] OP_OUT  = 4'b1011;

   logic [15:0] regs_q [8];
   logic [15:0] regs_d [8];
   logic [15:0] dataout_q, dataout_d;

   logic [3:0]  opcode;
   logic [2:0]  rd, rs1, rs2;
   logic [8:0]  imm9;
   logic [5:0]  imm6;
   logic [3:0]  sh;
   logic [15:0] a, b;
   logic [16:0] sum17;
   logic [15:0] result;
   logic        wr_en;

   assign opcode = bus.datain[15:12];
   assign rd     = bus.datain[11:9];
   assign rs1    = bus.datain[8:6];
   assign rs2    = bus.datain[5:3];
   assign imm9   = bus.datain[8:0];
   assign imm6   = bus.datain[5:0];
   assign sh     = bus.datain[3:0];
   assign a      = regs_q[rs1];
   assign b      = regs_q[rs2];

   // Decode and compute the result of the presented instruction.
   always_comb begin
      result = 16'h0000;
      sum17  = 17'h00000;
      wr_en  = 1'b0;
      case (opcode)
         OP_LDI: begin
            result = {7'b0, imm9};
            wr_en  = 1'b1;
         end
         OP_LUI: begin
            result = {imm9[6:0], 9'b0};
            wr_en  = 1'b1;
         end
         OP_ADD: begin
            sum17  = {1'b0, a} + {1'b0, b};
            result = sum17[15:0];
            wr_en  = 1'b1;
         end
         OP_SUB: begin
            sum17  = {1'b0, a} - {1'b0, b};
            result = sum17[15:0];
            wr_en  = 1'b1;
         end
         OP_AND: begin
            result = a & b;
            wr_en  = 1'b1;
         end
         OP_OR: begin
            result = a | b;
            wr_en  = 1'b1;
         end
         OP_XOR: begin
            result = a ^ b;
            wr_en  = 1'b1;
         end
         OP_NOT: begin
            result = ~a;
            wr_en  = 1'b1;
         end
         OP_SHL: begin
            result = a << sh;
            wr_en  = 1'b1;
         end
         OP_SHR: begin
            result = a >> sh;
            wr_en  = 1'b1;
         end
         OP_ADDI: begin
            sum17  = {1'b0, a} + {11'b0, imm6};
            result = sum17[15:0];
            wr_en  = 1'b1;
         end
         OP_OUT: begin
            result = a;
         end
         default: begin
            result = 16'h0000;
         end
      endcase
   end

   // Next-state for registers and the output latch.
   always_comb begin
      regs_d    = regs_q;
      dataout_d = dataout_q;
      if (wr_en) begin
         regs_d[rd] = result;
         dataout_d  = result;
      end else if (opcode == OP_OUT) begin
         dataout_d = result;
      end
   end

   // Architectural state update, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
         dataout_q <= 16'h0000;
      end else begin
         for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
         dataout_q <= dataout_d;
      end
   end

   assign bus.dataout = dataout_q;

`ifdef CPU_FLAGS_EN
   logic [1:0] flags_q, flags_d;
   logic       arith;

   assign arith = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                  (opcode == OP_ADDI);

   // Carry/borrow and zero from the arithmetic ops only.
   always_comb begin
      flags_d = flags_q;
      if (arith) flags_d = {sum17[16], (result == 16'h0000)};
   end

   // Flag register, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) flags_q <= 2'b00;
      else     flags_q <= flags_d;
   end

   assign bus.flags = flags_q;
`endif

endmodule

// File: tb/tb_cpu_top.sv
// Directed-vector bench for cpu_top.
// Covers reset, each opcode class, held words, wrap and mid-stream reset.
module tb_cpu_top;
   logic clk;
   logic rst;
   int   n_vec;
   int   n_bad;

   cpu_if bus ();

   cpu_top dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic r, input logic [15:0] w,
                       input logic [15:0] exp, input string tag);
      @(negedge clk);
      rst = r;
      bus.datain = w;
      @(posedge clk);
      #1;
      n_vec++;
      assert (bus.dataout === exp) else begin
         n_bad++;
         $error("FAIL %s dataout=%h expected=%h", tag, bus.dataout, exp);
      end
   endtask

   task automatic chk_flags(input logic [1:0] exp, input string tag);
`ifdef CPU_FLAGS_EN
      n_vec++;
      assert (bus.flags === exp) else begin
         n_bad++;
         $error("FAIL %s flags=%b expected=%b", tag, bus.flags, exp);
      end
`endif
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst = 1'b1;
      bus.datain = 16'h0000;

      step(1'b1, 16'h0000, 16'h0000, "reset");
      chk_flags(2'b00, "reset_flags");
      for (int k = 0; k < 8; k++)
         step(1'b0, 16'hB000 | 16'(k << 6), 16'h0000, "reg_zero");

      step(1'b0, 16'h003A, 16'h003A, "ldi_r0");
      step(1'b0, 16'h29C0, 16'h003A, "add_r4");
      chk_flags(2'b00, "add_flags");
      step(1'b0, 16'h29C0, 16'h003A, "add_held");
      step(1'b0, 16'h004B, 16'h004B, "ldi_r0_75");
      step(1'b0, 16'h3200, 16'h0000, "sub_r1");
      chk_flags(2'b01, "sub_zero1");
      step(1'b0, 16'h3800, 16'h0000, "sub_r4");
      chk_flags(2'b01, "sub_zero2");
      step(1'b0, 16'h3300, 16'hFFB5, "sub_borrow");
      chk_flags(2'b10, "sub_borrow_flags");

      step(1'b0, 16'h05FF, 16'h01FF, "ldi_r2");
      step(1'b0, 16'h8482, 16'h07FC, "shl2");
      step(1'b0, 16'h9481, 16'h03FE, "shr1");
      step(1'b0, 16'h9480, 16'h03FE, "shr0");
      step(1'b0, 16'hB080, 16'h03FE, "out_r2");
      step(1'b0, 16'hF000, 16'h03FE, "nop");
      chk_flags(2'b10, "nop_flags_hold");

      step(1'b0, 16'h0CF0, 16'h00F0, "ldi_r6");
      step(1'b0, 16'h4EB0, 16'h00F0, "and");
      step(1'b0, 16'h5EB0, 16'h03FE, "or");
      step(1'b0, 16'h6EB0, 16'h030E, "xor");
      step(1'b0, 16'h7F80, 16'hFF0F, "not");
      step(1'b0, 16'hC123, 16'hFF0F, "nop_c");
      step(1'b0, 16'h1BFF, 16'hFE00, "lui_r5");
      step(1'b0, 16'h2B68, 16'hFC00, "add_wrap");
      chk_flags(2'b10, "add_carry");

      step(1'b0, 16'h0600, 16'h0000, "ldi_r3_0");
      step(1'b0, 16'h0A02, 16'h0002, "ldi_r5_2");
      step(1'b0, 16'h36E8, 16'hFFFE, "sub_r3");
      step(1'b0, 16'hA6C1, 16'hFFFF, "addi_1");
      chk_flags(2'b00, "addi_f1");
      step(1'b0, 16'hA6C1, 16'h0000, "addi_2");
      chk_flags(2'b11, "addi_f2");
      step(1'b0, 16'hA6C1, 16'h0001, "addi_3");
      chk_flags(2'b00, "addi_f3");
      step(1'b1, 16'hA6C1, 16'h0000, "mid_reset");
      chk_flags(2'b00, "mid_reset_flags");
      step(1'b0, 16'hB0C0, 16'h0000, "r3_after_rst");
      step(1'b0, 16'hB080, 16'h0000, "r2_after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
